// File: rtl/axis_ad9226_pkg.sv
// Shared types and constants for the AD9226 sample-to-AXI-Stream path.
package axis_ad9226_pkg;

  localparam int SAMPLE_WIDTH    = 16;
  localparam int AXIS_DATA_WIDTH = 2 * SAMPLE_WIDTH;

  // Sample pairing state: low half of a beat either pending or not.
  typedef enum logic {
    PAIR_EMPTY = 1'b0,
    PAIR_HALF  = 1'b1
  } pair_state_e;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// A push while full is accepted only when a pop happens on the same edge.
module axis_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
);

  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_wr;
  logic                  w_rd;

  assign full    = (r_count == CNT_FULL);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_rd    = pop & ~empty;
  assign w_wr    = push & (~full | w_rd);

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axis_sample_packetizer.sv
// Packs pairs of averaged ADC samples into 32-bit AXI-Stream beats, buffers
// them, frames packets with tlast and flags beats lost to a stalled sink.
//
// state      | meaning
// PAIR_EMPTY | no sample pending; next accepted sample becomes the low half
// PAIR_HALF  | low half held; next accepted sample completes and pushes a beat
module axis_sample_packetizer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [LEN_WIDTH-1:0]      packet_len,
  input  logic                      in_data_valid,
  input  logic [SAMPLE_WIDTH-1:0]   in_data,
  output logic [2*SAMPLE_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      overflow,
  input  logic                      overflow_clr
);

  import axis_ad9226_pkg::*;

  localparam int DW = 2 * SAMPLE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  pair_state_e             r_pair_state;
  pair_state_e             w_pair_next;
  logic [SAMPLE_WIDTH-1:0] r_low;
  logic                    w_push;
  logic [DW-1:0]           w_push_data;

  logic [DW-1:0]           w_fifo_rd_data;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [AW:0]             w_fifo_count_unused;
  logic                    w_load;
  logic                    w_drop;

  logic [DW-1:0]           r_tdata;
  logic                    r_tvalid;
  logic                    r_tlast;
  logic                    r_overflow;

  logic [LEN_WIDTH-1:0]    r_beat_cnt;
  logic [LEN_WIDTH-1:0]    r_len_latched;
  logic [LEN_WIDTH-1:0]    w_len_in;
  logic [LEN_WIDTH-1:0]    w_len_cur;
  logic                    w_last;

  // Pair FSM next state; dropping enable abandons any pending half-sample.
  always_comb begin
    w_pair_next = r_pair_state;
    w_push      = 1'b0;
    if (!enable) begin
      w_pair_next = PAIR_EMPTY;
    end else if (in_data_valid) begin
      case (r_pair_state)
        PAIR_EMPTY: w_pair_next = PAIR_HALF;
        PAIR_HALF: begin
          w_pair_next = PAIR_EMPTY;
          w_push      = 1'b1;
        end
        default: w_pair_next = PAIR_EMPTY;
      endcase
    end
  end

  // Pair FSM state register and low-half capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pair_state <= PAIR_EMPTY;
      r_low        <= '0;
    end else begin
      r_pair_state <= w_pair_next;
      if (enable && in_data_valid && (r_pair_state == PAIR_EMPTY)) r_low <= in_data;
    end
  end

  assign w_push_data = {in_data, r_low};

  axis_sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (w_push_data),
    .pop     (w_load),
    .rd_data (w_fifo_rd_data),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count_unused)
  );

  // The output register refills whenever it is free or being consumed this edge.
  assign w_load = ~w_fifo_empty & (~r_tvalid | m_axis_tready);
  assign w_drop = w_push & w_fifo_full & ~w_load;

  // A fresh packet takes the live length; mid-packet it stays on the latched one.
  assign w_len_in  = (packet_len == '0) ? LEN_ONE : packet_len;
  assign w_len_cur = (r_beat_cnt == '0) ? w_len_in : r_len_latched;
  assign w_last    = (r_beat_cnt == (w_len_cur - LEN_ONE));

  // Output slice and beat framing; beats are counted as they enter the register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_beat_cnt    <= '0;
      r_len_latched <= LEN_ONE;
    end else begin
      if (r_beat_cnt == '0) r_len_latched <= w_len_in;
      if (w_load) begin
        r_tvalid   <= 1'b1;
        r_tdata    <= w_fifo_rd_data;
        r_tlast    <= w_last;
        r_beat_cnt <= w_last ? '0 : (r_beat_cnt + LEN_ONE);
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  // Sticky loss flag; a new drop outranks a clear on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_axis_sample_packetizer.sv
// Directed bench for axis_sample_packetizer with an expected-beat scoreboard.
module tb_axis_sample_packetizer;

  localparam int SW = 16;
  localparam int DW = 32;
  localparam int FD = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [LW-1:0] packet_len = 16'd1;
  logic          in_data_valid = 1'b0;
  logic [SW-1:0] in_data = '0;
  logic          m_axis_tready = 1'b0;
  logic          overflow_clr = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // scoreboard entries are {tlast, tdata}
  logic [DW:0]   exp_q[$];
  int            held = 0;
  logic          m_half = 1'b0;
  logic [SW-1:0] m_low = '0;
  int            fcnt = 0;
  int            flen = 1;
  logic          exp_ovf = 1'b0;
  logic          m_drop = 1'b0;
  int            n_last = 0;
  logic          stalled = 1'b0;
  logic [DW:0]   stall_val = '0;

  axis_sample_packetizer #(
    .SAMPLE_WIDTH (SW),
    .FIFO_DEPTH   (FD),
    .LEN_WIDTH    (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .packet_len    (packet_len),
    .in_data_valid (in_data_valid),
    .in_data       (in_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: a completed beat survives if DUT storage (FIFO + output register) has room.
  task automatic push_model(input logic [DW-1:0] beat);
    logic last;
    m_drop = 1'b0;
    if (held < FD + 1) begin
      if (fcnt == 0) flen = (packet_len == '0) ? 1 : int'(packet_len);
      last = (fcnt == flen - 1);
      fcnt = last ? 0 : fcnt + 1;
      exp_q.push_back({last, beat});
      held++;
    end else begin
      m_drop  = 1'b1;
      exp_ovf = 1'b1;
    end
  endtask

  task automatic send(input logic [SW-1:0] d, input logic clr);
    in_data       = d;
    in_data_valid = 1'b1;
    overflow_clr  = clr;
    m_drop        = 1'b0;
    @(negedge clk);
    #1;
    if (enable) begin
      if (!m_half) begin
        m_half = 1'b1;
        m_low  = d;
      end else begin
        m_half = 1'b0;
        push_model({d, m_low});
      end
    end
    if (clr && !m_drop) exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    in_data_valid = 1'b0;
    overflow_clr  = 1'b0;
  endtask

  task automatic set_en(input logic v);
    enable = v;
    if (!v) m_half = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
      tick(1);
      n++;
    end
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_tvalid_idle"}, m_axis_tvalid, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    held    = 0;
    m_half  = 1'b0;
    fcnt    = 0;
    exp_ovf = 1'b0;
  endtask

  // Sink monitor: scoreboard on every handshake, stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      if (stalled) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, stall_val});
      if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        if (m_axis_tlast) n_last++;
        held--;
      end
      stalled   = m_axis_tvalid && !m_axis_tready;
      stall_val = {m_axis_tlast, m_axis_tdata};
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    int base;

    // 1: reset held for 3 edges while valid toggles
    enable        = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data       = SW'(16'h1230 + i);
      in_data_valid = (i != 1);
      tick(1);
    end
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_overflow", overflow, 1'b0);
    in_data_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    tick(3);
    chk("post_rst_tvalid", m_axis_tvalid, 1'b0);

    // 2: one pair appears within 2 edges of the second sample
    packet_len = 16'd1;
    send(16'h0001, 1'b0);
    send(16'hFFFE, 1'b0);
    tick(1);
    chk("pair_tvalid", m_axis_tvalid, 1'b1);
    chk("pair_tdata", m_axis_tdata, 32'hFFFE0001);
    drain("pair");

    // 3: framing with packet_len 4, then 0 (treated as 1)
    packet_len = 16'd4;
    base = n_last;
    for (int i = 0; i < 16; i++) send(SW'(16'h0101 * i + 16'h0003), 1'b0);
    drain("frame4");
    chk("frame4_lasts", n_last - base, 2);
    packet_len = 16'd0;
    base = n_last;
    for (int i = 0; i < 6; i++) send(SW'(16'h8000 + i), 1'b0);
    drain("frame0");
    chk("frame0_lasts", n_last - base, 3);

    // 5a: enable drop discards the pending half
    packet_len = 16'd1;
    send(16'h7777, 1'b0);
    set_en(1'b0);
    send(16'h1234, 1'b0);
    tick(1);
    set_en(1'b1);
    send(16'hAAAA, 1'b0);
    send(16'h5555, 1'b0);
    tick(1);
    chk("en_tdata", m_axis_tdata, 32'h5555AAAA);
    drain("enable");

    // 5b: packet_len 4 -> 2 mid-packet
    packet_len = 16'd4;
    base = n_last;
    for (int i = 0; i < 4; i++) send(SW'(16'h4000 + i), 1'b0);
    drain("len_a");
    chk("len_a_lasts", n_last - base, 0);
    packet_len = 16'd2;
    for (int i = 0; i < 12; i++) send(SW'(16'h4100 + i), 1'b0);
    drain("len_b");
    chk("len_b_lasts", n_last - base, 3);

    // 4: backpressure, FIFO_DEPTH+1 beats held, rest dropped
    packet_len    = 16'd4;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 2 * FD + 6; i++) send(SW'(16'hC000 + i), 1'b0);
    tick(2);
    chk("bp_tvalid", m_axis_tvalid, 1'b1);
    chk("bp_tdata_first", m_axis_tdata, 32'hC001C000);
    chk("bp_overflow", overflow, exp_ovf);

    // 6: clear on the same edge as a new drop loses; clear alone wins
    send(16'h0A0A, 1'b0);
    send(16'h0B0B, 1'b1);
    chk("ovf_set_wins", overflow, exp_ovf);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_clr", overflow, exp_ovf);
    m_axis_tready = 1'b1;
    drain("bp");
    chk("bp_overflow_after", overflow, 1'b0);

    // reset mid-packet discards held beat and half-pair
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(SW'(16'hD000 + i), 1'b0);
    tick(2);
    chk("mid_held", m_axis_tvalid, 1'b1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    model_reset();
    chk("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    m_axis_tready = 1'b1;
    send(16'h0102, 1'b0);
    send(16'h0304, 1'b0);
    tick(1);
    chk("mid_rst_tdata", m_axis_tdata, 32'h03040102);
    drain("mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
